// File: rtl/nonce_result_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nonce_result_scan_pkg
// Purpose  : Shared types and result-record layout for the nonce result scan,
//            the bitcoin hash engine and the host driver.
// Revision : 1.0  initial release
// ============================================================================
package nonce_result_scan_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_WR0   = 3'd3,
        S_WR1   = 3'd4,
        S_FIN   = 3'd5
    } scan_state_t;

    localparam int FOUND_BIT     = 31;
    localparam int FIRST_IDX_LSB = 16;
    localparam int MIN_IDX_LSB   = 0;

    function automatic logic [31:0] pack_result(
        input logic       found,
        input logic [7:0] first_idx,
        input logic [7:0] min_idx
    );
        logic [31:0] w;
        w                        = '0;
        w[FOUND_BIT]             = found;
        w[FIRST_IDX_LSB +: 8]    = first_idx;
        w[MIN_IDX_LSB +: 8]      = min_idx;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nonce_result_scan_tracker.sv
`default_nettype none
// ============================================================================
// Module   : nonce_result_scan_tracker
// Purpose  : Running minimum and first-below-target tracking over a word stream.
// Revision : 1.0  initial release
// ============================================================================
module nonce_result_scan_tracker #(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             valid,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      word,
    input  logic [31:0]      target,
    output logic             found,
    output logic [IDX_W-1:0] first_idx,
    output logic [31:0]      min_hash,
    output logic [IDX_W-1:0] min_idx,
    output logic             found_nxt,
    output logic [IDX_W-1:0] first_idx_nxt,
    output logic [31:0]      min_hash_nxt,
    output logic [IDX_W-1:0] min_idx_nxt
);

    logic             found_q,     found_d;
    logic [IDX_W-1:0] first_idx_q, first_idx_d;
    logic [31:0]      min_hash_q,  min_hash_d;
    logic [IDX_W-1:0] min_idx_q,   min_idx_d;

    always_comb begin
        found_d     = found_q;
        first_idx_d = first_idx_q;
        min_hash_d  = min_hash_q;
        min_idx_d   = min_idx_q;
        if (clear) begin
            found_d     = 1'b0;
            first_idx_d = '0;
        end else if (valid) begin
            // Index 0 seeds the minimum; strict compare keeps the lowest index on ties.
            if ((idx == '0) || (word < min_hash_q)) begin
                min_hash_d = word;
                min_idx_d  = idx;
            end
            if (!found_q && (word < target)) begin
                found_d     = 1'b1;
                first_idx_d = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            found_q     <= 1'b0;
            first_idx_q <= '0;
            min_hash_q  <= '0;
            min_idx_q   <= '0;
        end else begin
            found_q     <= found_d;
            first_idx_q <= first_idx_d;
            min_hash_q  <= min_hash_d;
            min_idx_q   <= min_idx_d;
        end
    end

    assign found         = found_q;
    assign first_idx     = first_idx_q;
    assign min_hash      = min_hash_q;
    assign min_idx       = min_idx_q;
    assign found_nxt     = found_d;
    assign first_idx_nxt = first_idx_d;
    assign min_hash_nxt  = min_hash_d;
    assign min_idx_nxt   = min_idx_d;

endmodule
`default_nettype wire

// File: rtl/nonce_result_scan.sv
`default_nettype none
// ============================================================================
// Module   : nonce_result_scan
// Purpose  : Reads back per-nonce hash words, finds first match and minimum,
//            and writes a 2-word result record over the shared memory port.
// Revision : 1.0  initial release
// ============================================================================
module nonce_result_scan
    import nonce_result_scan_pkg::*;
#(
    parameter int NUM_NONCES = 16,
    parameter int IDX_W      = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [15:0]      hash_addr,
    input  logic [15:0]      result_addr,
    input  logic [31:0]      target,
    output logic             done,
    output logic             found,
    output logic [IDX_W-1:0] first_idx,
    output logic [31:0]      min_hash,
    output logic [IDX_W-1:0] min_idx,
    output logic             mem_clk,
    output logic             mem_we,
    output logic [15:0]      mem_addr,
    output logic [31:0]      mem_write_data,
    input  logic [31:0]      mem_read_data
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NONCES - 1);

    scan_state_t      state_q, state_d;
    logic [IDX_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             cmp_valid_q, cmp_valid_d;
    logic [IDX_W-1:0] cmp_idx_q, cmp_idx_d;
    logic [15:0]      result_addr_q, result_addr_d;
    logic [31:0]      target_q, target_d;
    logic             mem_we_q, mem_we_d;
    logic [15:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             done_q, done_d;

    logic             start_accept;
    logic             found_nxt;
    logic [IDX_W-1:0] first_idx_nxt;
    logic [31:0]      min_hash_nxt;
    logic [IDX_W-1:0] min_idx_nxt;

    assign start_accept = (state_q == S_IDLE) && start;

    nonce_result_scan_tracker #(
        .IDX_W (IDX_W)
    ) u_tracker (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear         (start_accept),
        .valid         (cmp_valid_q),
        .idx           (cmp_idx_q),
        .word          (mem_read_data),
        .target        (target_q),
        .found         (found),
        .first_idx     (first_idx),
        .min_hash      (min_hash),
        .min_idx       (min_idx),
        .found_nxt     (found_nxt),
        .first_idx_nxt (first_idx_nxt),
        .min_hash_nxt  (min_hash_nxt),
        .min_idx_nxt   (min_idx_nxt)
    );

    always_comb begin
        state_d       = state_q;
        rd_cnt_d      = rd_cnt_q;
        result_addr_d = result_addr_q;
        target_d      = target_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_we_d      = 1'b0;
        done_d        = 1'b0;
        // Read data lags the issued address by one cycle.
        cmp_valid_d   = (state_q == S_READ);
        cmp_idx_d     = rd_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    result_addr_d = result_addr;
                    target_d      = target;
                    mem_addr_d    = hash_addr;
                    rd_cnt_d      = '0;
                    state_d       = S_READ;
                end
            end
            S_READ: begin
                mem_addr_d = mem_addr_q + 16'd1;
                rd_cnt_d   = rd_cnt_q + 1'b1;
                if (rd_cnt_q == LAST_IDX) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Last word is compared this cycle, so the record uses next-state results.
                mem_we_d    = 1'b1;
                mem_addr_d  = result_addr_q;
                mem_wdata_d = pack_result(found_nxt, 8'(first_idx_nxt), 8'(min_idx_nxt));
                state_d     = S_WR0;
            end
            S_WR0: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = result_addr_q + 16'd1;
                mem_wdata_d = min_hash;
                state_d     = S_WR1;
            end
            S_WR1: begin
                done_d  = 1'b1;
                state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            rd_cnt_q      <= '0;
            cmp_valid_q   <= 1'b0;
            cmp_idx_q     <= '0;
            result_addr_q <= '0;
            target_q      <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_cnt_q      <= rd_cnt_d;
            cmp_valid_q   <= cmp_valid_d;
            cmp_idx_q     <= cmp_idx_d;
            result_addr_q <= result_addr_d;
            target_q      <= target_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            done_q        <= done_d;
        end
    end

    assign done           = done_q;
    assign mem_clk        = clk;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_nonce_result_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_nonce_result_scan
// Purpose  : Scoreboard bench for nonce_result_scan with a 1-cycle-latency memory.
// Revision : 1.0  initial release
// ============================================================================
module tb_nonce_result_scan;

    localparam int N  = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   hash_addr = '0;
    logic [15:0]   result_addr = '0;
    logic [31:0]   target = '0;
    logic          done, found, mem_clk, mem_we;
    logic [IW-1:0] first_idx, min_idx;
    logic [31:0]   min_hash, mem_write_data;
    logic [15:0]   mem_addr;
    logic [31:0]   mem_read_data = '0;

    logic [31:0] mem [0:65535];

    typedef struct {
        logic          found;
        logic [IW-1:0] first_idx;
        logic [31:0]   min_hash;
        logic [IW-1:0] min_idx;
        logic [31:0]   word0;
        logic [15:0]   rec;
        int            start_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] wr_q[$];
    int          cyc = 0;
    int          passes = 0;
    int          total = 0;
    bit          chk_low = 1'b0;
    exp_t        mon_e;
    logic [15:0] mon_r1;

    nonce_result_scan #(.NUM_NONCES(N)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .hash_addr      (hash_addr),
        .result_addr    (result_addr),
        .target         (target),
        .done           (done),
        .found          (found),
        .first_idx      (first_idx),
        .min_hash       (min_hash),
        .min_idx        (min_idx),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) mem[mem_addr] <= mem_write_data;
        mem_read_data <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every done pulse pops one expected result and checks ports and the record.
    always @(negedge clk) begin
        if (chk_low) begin
            chk("done_one_cycle", done, 0);
            chk_low = 1'b0;
        end
        if (mem_we) wr_q.push_back(mem_addr);
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e  = sb.pop_front();
                mon_r1 = mon_e.rec + 16'd1;
                chk("found",     found,     mon_e.found);
                chk("first_idx", first_idx, mon_e.first_idx);
                chk("min_hash",  min_hash,  mon_e.min_hash);
                chk("min_idx",   min_idx,   mon_e.min_idx);
                chk("latency",   cyc - mon_e.start_cyc, N + 4);
                chk("rec_word0", mem[mon_e.rec], mon_e.word0);
                chk("rec_word1", mem[mon_r1],    mon_e.min_hash);
                chk("wr_count",  wr_q.size(), 2);
                if (wr_q.size() >= 2) begin
                    chk("wr_addr0", wr_q[0], mon_e.rec);
                    chk("wr_addr1", wr_q[1], mon_r1);
                end
                chk_low = 1'b1;
            end
            wr_q.delete();
        end
    end

    task automatic start_scan(input logic [15:0] ha, input logic [15:0] ra, input logic [31:0] tg,
                              input bit push, input exp_t e);
        @(negedge clk);
        hash_addr   = ha;
        result_addr = ra;
        target      = tg;
        start       = 1'b1;
        e.rec       = ra;
        e.start_cyc = cyc;
        if (push) sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 1, 0);
    endtask

    function automatic exp_t mk(input logic f, input logic [IW-1:0] fi, input logic [31:0] mh,
                                input logic [IW-1:0] mi, input logic [31:0] w0);
        exp_t e;
        e.found = f; e.first_idx = fi; e.min_hash = mh; e.min_idx = mi; e.word0 = w0;
        e.rec = '0; e.start_cyc = 0;
        return e;
    endfunction

    initial begin
        int n;
        for (int i = 0; i < N; i++) begin
            mem[16'h0100 + 16'(i)] = 32'h9000_0000 - 32'(i);
            mem[16'h0300 + 16'(i)] = 32'hFFFF_FFFF;
            mem[16'h0500 + 16'(i)] = 32'hFFFF_0000;
            mem[16'hFFF8 + 16'(i)] = 32'h2000_0000 + 32'(i) * 32'h100;
        end
        mem[16'h0305] = 32'h0000_1234;
        mem[16'h0309] = 32'h0000_0001;
        mem[16'h0503] = 32'h0000_0010;
        mem[16'h0507] = 32'h0000_0010;
        mem[16'h0004] = 32'h0000_0050;   // index 12 of the wrapped region

        #2 reset_n = 1'b0;
        #1;
        chk("rst_done", done, 0);
        chk("rst_found", found, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_min_hash", min_hash, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Descending words, nothing below target.
        start_scan(16'h0100, 16'h0200, 32'h8000_0000, 1, mk(0, 0, 32'h8FFF_FFF1, 15, 32'h0000_000F));
        wait_done();

        // Two matches; extra start pulses in READ and FIN must be ignored.
        start_scan(16'h0300, 16'h0400, 32'h0001_0000, 1, mk(1, 5, 32'h1, 9, 32'h8005_0009));
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (30) @(negedge clk);

        // Back-to-back: target 0 then target 2 over the same words.
        start_scan(16'h0300, 16'h0410, 32'h0000_0000, 1, mk(0, 0, 32'h1, 9, 32'h0000_0009));
        wait_done();
        start_scan(16'h0300, 16'h0420, 32'h0000_0002, 1, mk(1, 9, 32'h1, 9, 32'h8009_0009));
        wait_done();

        // Address wrap on both reads and the record; inputs changed mid-scan.
        start_scan(16'hFFF8, 16'hFFFF, 32'h0000_1000, 1, mk(1, 12, 32'h50, 12, 32'h800C_000C));
        @(negedge clk);
        hash_addr = 16'h1234; result_addr = 16'h5555; target = 32'h0;
        wait_done();

        // Reset while the first record word is being written.
        mem[16'h0700] = 32'hDEAD_BEEF;
        mem[16'h0701] = 32'hCAFE_F00D;
        start_scan(16'h0300, 16'h0700, 32'h0001_0000, 0, mk(0, 0, 0, 0, 0));
        n = 0;
        while (!mem_we && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("we_reached", mem_we, 1);
        reset_n = 1'b0;
        #1;
        chk("abort_mem_we", mem_we, 0);
        chk("abort_done", done, 0);
        chk("abort_found", found, 0);
        chk("abort_min_idx", min_idx, 0);
        chk("abort_wdata", mem_write_data, 0);
        repeat (2) @(negedge clk);
        wr_q.delete();
        chk("abort_rec0", mem[16'h0700], 32'hDEAD_BEEF);
        chk("abort_rec1", mem[16'h0701], 32'hCAFE_F00D);
        reset_n = 1'b1;

        // Duplicate minima equal to target: no match, lowest index wins.
        start_scan(16'h0500, 16'h0600, 32'h0000_0010, 1, mk(0, 0, 32'h10, 3, 32'h0000_0003));
        wait_done();
        repeat (5) @(negedge clk);

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
